// File: rtl/dual_rank_pkg.sv
// Shared widths, geometry and FSM encoding for the dual-rank RAM controller.
package dual_rank_pkg;

  localparam int WORDADDR_WIDTH = 7;
  localparam int DATA_WIDTH     = 8;
  localparam int DEPTH          = 128;
  localparam int RANKS          = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RDWAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/dual_rank_mem_ctrl.sv
// Single-outstanding host-to-RAM bridge for two RAMB128x8 ranks sharing one bus.
// RAM-side outputs are registered; read data returns one cycle after the select.
module dual_rank_mem_ctrl #(
  parameter int WORDADDR_WIDTH = dual_rank_pkg::WORDADDR_WIDTH,
  parameter int DATA_WIDTH     = dual_rank_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [WORDADDR_WIDTH:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      cs0,
  output logic                      cs1,
  output logic                      wr,
  output logic [WORDADDR_WIDTH-1:0] wordAddr,
  output logic [DATA_WIDTH-1:0]     dataIn,
  input  logic [DATA_WIDTH-1:0]     dataOut0,
  input  logic [DATA_WIDTH-1:0]     dataOut1,
  output logic [CNT_WIDTH-1:0]      rd_cnt,
  output logic [CNT_WIDTH-1:0]      wr_cnt
);
  import dual_rank_pkg::*;

  state_t state, state_nxt;
  logic   lat_wr;
  logic   lat_rank;
  logic   hs;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign hs        = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = lat_wr ? S_IDLE : S_RDWAIT;
      S_RDWAIT: state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Selects are loaded on the handshake edge so they are high for exactly the
  // ISSUE cycle; wordAddr/dataIn double as the request latch and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat_wr    <= 1'b0;
      lat_rank  <= 1'b0;
      cs0       <= 1'b0;
      cs1       <= 1'b0;
      wr        <= 1'b0;
      wordAddr  <= '0;
      dataIn    <= '0;
      rsp_rdata <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      state <= state_nxt;
      cs0   <= 1'b0;
      cs1   <= 1'b0;
      wr    <= 1'b0;
      if (hs) begin
        lat_wr   <= req_wr;
        lat_rank <= req_addr[WORDADDR_WIDTH];
        cs0      <= ~req_addr[WORDADDR_WIDTH];
        cs1      <= req_addr[WORDADDR_WIDTH];
        wr       <= req_wr;
        wordAddr <= req_addr[WORDADDR_WIDTH-1:0];
        dataIn   <= req_wdata;
      end
      if (state == S_ISSUE && lat_wr)
        wr_cnt <= wr_cnt + CNT_WIDTH'(1);
      if (state == S_RDWAIT)
        rsp_rdata <= lat_rank ? dataOut1 : dataOut0;
      if (state == S_RESP && rsp_ready)
        rd_cnt <= rd_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_dual_rank_mem_ctrl.sv
module tb_dual_rank_mem_ctrl;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int CW = 10;
  localparam int CMOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_wr;
  logic [AW:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          cs0, cs1, wr;
  logic [AW-1:0] wordAddr;
  logic [DW-1:0] dataIn;
  logic [DW-1:0] dataOut0, dataOut1;
  logic [CW-1:0] rd_cnt, wr_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dual_rank_mem_ctrl #(.WORDADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .cs0(cs0), .cs1(cs1), .wr(wr), .wordAddr(wordAddr), .dataIn(dataIn),
    .dataOut0(dataOut0), .dataOut1(dataOut1),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  logic [DW-1:0] mem0 [128];
  logic [DW-1:0] mem1 [128];
  always @(posedge clk) begin
    if (cs0) begin
      if (wr) mem0[wordAddr] <= dataIn;
      else    dataOut0 <= mem0[wordAddr];
    end
    if (cs1) begin
      if (wr) mem1[wordAddr] <= dataIn;
      else    dataOut1 <= mem1[wordAddr];
    end
  end

  int cs0_n = 0;
  int cs1_n = 0;
  always @(negedge clk) begin
    if (cs0) cs0_n++;
    if (cs1) cs1_n++;
  end

  logic [DW-1:0] ref_mem [256];
  bit            written [256];
  int            ref_wr = 0;
  int            ref_rd = 0;

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", req_ready === 1'b1, req_ready, 1'b1);
  endtask

  task automatic issue(input logic w, input logic [AW:0] a, input logic [DW-1:0] d);
    wait_ready();
    req_valid = 1'b1; req_wr = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'($urandom); req_addr = (AW+1)'($urandom); req_wdata = DW'($urandom);
    chk("issue_cs0", cs0 === ~a[AW], cs0, ~a[AW]);
    chk("issue_cs1", cs1 === a[AW], cs1, a[AW]);
    chk("issue_wr", wr === w, wr, w);
    chk("issue_addr", wordAddr === a[AW-1:0], wordAddr, a[AW-1:0]);
    if (w) chk("issue_data", dataIn === d, dataIn, d);
    chk("issue_busy", req_ready === 1'b0, req_ready, 1'b0);
  endtask

  task automatic do_write(input logic [AW:0] a, input logic [DW-1:0] d);
    issue(1'b1, a, d);
    ref_mem[a] = d; written[a] = 1'b1;
    ref_wr = (ref_wr + 1) % CMOD;
    @(negedge clk);
    chk("wr_idle_cs", {cs0, cs1, wr} === 3'b000, {cs0, cs1, wr}, 3'b000);
    chk("wr_no_rsp", rsp_valid === 1'b0, rsp_valid, 1'b0);
    chk("wr_cnt", wr_cnt === CW'(ref_wr), wr_cnt, CW'(ref_wr));
    chk("wr_ready_again", req_ready === 1'b1, req_ready, 1'b1);
  endtask

  task automatic do_read(input logic [AW:0] a, input int hold);
    logic [DW-1:0] exp_d;
    exp_d = ref_mem[a];
    rsp_ready = 1'b0;
    issue(1'b0, a, DW'($urandom));
    @(negedge clk);
    chk("rd_wait_novalid", rsp_valid === 1'b0, rsp_valid, 1'b0);
    chk("rd_wait_cs", {cs0, cs1} === 2'b00, {cs0, cs1}, 2'b00);
    @(negedge clk);
    chk("rd_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
    chk("rd_data", rsp_rdata === exp_d, rsp_rdata, exp_d);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
      chk("bp_data", rsp_rdata === exp_d, rsp_rdata, exp_d);
      chk("bp_ready", req_ready === 1'b0, req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ref_rd = (ref_rd + 1) % CMOD;
    chk("rd_done_valid", rsp_valid === 1'b0, rsp_valid, 1'b0);
    chk("rd_cnt", rd_cnt === CW'(ref_rd), rd_cnt, CW'(ref_rd));
    chk("rd_done_ready", req_ready === 1'b1, req_ready, 1'b1);
  endtask

  task automatic burst(input int n);
    int c0, c1, e0, e1;
    logic [AW:0] a;
    c0 = cs0_n; c1 = cs1_n; e0 = 0; e1 = 0;
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = (AW+1)'($urandom);
      req_addr = a; req_wdata = DW'($urandom);
      ref_mem[a] = req_wdata; written[a] = 1'b1;
      if (a[AW]) e1++; else e0++;
      @(negedge clk);
      chk("b2b_busy", req_ready === 1'b0, req_ready, 1'b0);
      @(negedge clk);
      chk("b2b_ready", req_ready === 1'b1, req_ready, 1'b1);
      ref_wr = (ref_wr + 1) % CMOD;
    end
    req_valid = 1'b0;
    chk("b2b_wr_cnt", wr_cnt === CW'(ref_wr), wr_cnt, CW'(ref_wr));
    chk("b2b_cs0_pulses", (cs0_n - c0) === e0, cs0_n - c0, e0);
    chk("b2b_cs1_pulses", (cs1_n - c1) === e1, cs1_n - c1, e1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cs"}, {cs0, cs1, wr} === 3'b000, {cs0, cs1, wr}, 3'b000);
    chk({tag, "_rsp_valid"}, rsp_valid === 1'b0, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata === DW'(0), rsp_rdata, DW'(0));
    chk({tag, "_addr"}, wordAddr === AW'(0), wordAddr, AW'(0));
    chk({tag, "_din"}, dataIn === DW'(0), dataIn, DW'(0));
    chk({tag, "_cnts"}, {rd_cnt, wr_cnt} === (2*CW)'(0), {rd_cnt, wr_cnt}, (2*CW)'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    logic [AW:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", req_ready === 1'b1, req_ready, 1'b1);

    c0 = cs0_n; c1 = cs1_n;
    do_write(8'h05, 8'hA5);
    do_read(8'h05, 0);
    chk("r0_cs0_pulses", (cs0_n - c0) === 2, cs0_n - c0, 2);
    chk("r0_cs1_pulses", (cs1_n - c1) === 0, cs1_n - c1, 0);
    chk("r0_wr_cnt", wr_cnt === CW'(1), wr_cnt, CW'(1));
    chk("r0_rd_cnt", rd_cnt === CW'(1), rd_cnt, CW'(1));

    c0 = cs0_n; c1 = cs1_n;
    do_write(8'h85, 8'h3C);
    do_write(8'h05, 8'hC3);
    do_read(8'h85, 0);
    do_read(8'h05, 0);
    chk("alias_cs1_pulses", (cs1_n - c1) === 2, cs1_n - c1, 2);
    chk("alias_cs0_pulses", (cs0_n - c0) === 2, cs0_n - c0, 2);

    do_read(8'h85, 5);

    issue(1'b0, 8'h05, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    ref_wr = 0; ref_rd = 0;
    chk_reset_state("midrst");
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_valid", rsp_valid === 1'b0, rsp_valid, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_read(8'h05, 1);

    for (int i = 0; i < 60; i++) begin
      a = (AW+1)'($urandom);
      if ($urandom_range(1, 0) == 1 || !written[a]) do_write(a, DW'($urandom));
      else do_read(a, int'($urandom_range(3, 0)));
    end

    burst(6);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_wr = 0; ref_rd = 0;
    @(negedge clk);
    burst(CMOD - 1);
    chk("wrap_full", wr_cnt === {CW{1'b1}}, wr_cnt, {CW{1'b1}});
    do_write(8'h7F, 8'h5A);
    chk("wrap_zero", wr_cnt === CW'(0), wr_cnt, CW'(0));
    do_read(8'h7F, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
